// File: rtl/mod_n_pkg.sv
// Shared constants and the modulus range check for the modulo-N up/down counter.
package mod_n_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // A modulus is legal when 2 <= val <= 2**width.
  function automatic logic mod_legal(input int val, input int width);
    return (val >= 2) && (val <= (1 << width));
  endfunction

endpackage

// File: rtl/mod_n_mod_ctrl.sv
// Modulus control: current/pending modulus registers, legality check, mod_err and apply strobe.
module mod_n_mod_ctrl
  import mod_n_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  input  logic             apply_req,
  input  logic             load_err,
  output logic [WIDTH:0]   mod_cur,
  output logic             mod_pend,
  output logic             mod_err,
  output logic [WIDTH:0]   mod_eff
);

  localparam int MW = WIDTH + 1;

  logic [MW-1:0] cur_q, cur_d;
  logic [MW-1:0] pend_val_q, pend_val_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          legal;
  logic          apply;

  assign legal = mod_legal(int'(mod_val), WIDTH);
  assign apply = apply_req & pend_q;

  // The edge that applies the pending value still sees the old modulus in the
  // registers, so the count datapath needs this forwarded value.
  assign mod_eff = apply ? pend_val_q : cur_q;

  always_comb begin
    cur_d      = cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    err_d      = (mod_wr & ~legal) | load_err;
    if (apply) begin
      cur_d  = pend_val_q;
      pend_d = 1'b0;
    end
    if (mod_wr && legal) begin
      pend_val_d = mod_val;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_q      <= MW'(N);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign mod_cur  = cur_q;
  assign mod_pend = pend_q;
  assign mod_err  = err_q;

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with preload, staged runtime modulus and terminal count.
// Optional MODN_SATURATE_EN adds a sat input that holds at the end of range instead of wrapping.
module mod_n_updown_counter
  import mod_n_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic [WIDTH:0]   mod_cur,
  output logic             mod_pend,
  output logic             mod_err
`ifdef MODN_SATURATE_EN
  ,
  input  logic             sat
`endif
);

  localparam int MW = WIDTH + 1;

  if (!mod_legal(N, WIDTH)) begin : g_bad_n
    $error("mod_n_updown_counter: N must satisfy 2 <= N <= 2**WIDTH");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    mod_eff;
  logic [WIDTH-1:0] top_val;
  logic             at_top, at_bot;
  logic             sat_hold;
  logic             wrap;
  logic             load_ok;
  logic             load_err;
  logic             apply_req;

  // Wrap detection uses the modulus in effect; comparisons are WIDTH+1 wide so
  // M = 2**WIDTH terminates at all-ones.
  assign at_top  = ({1'b0, cnt_q} == (mod_cur - MW'(1)));
  assign at_bot  = (cnt_q == '0);
  assign top_val = WIDTH'(mod_eff - MW'(1));

`ifdef MODN_SATURATE_EN
  assign sat_hold = sat & ((up_dn == DIR_UP) ? at_top : at_bot);
`else
  assign sat_hold = 1'b0;
`endif

  assign wrap      = en & ~load & ~sat_hold & ((up_dn == DIR_UP) ? at_top : at_bot);
  assign apply_req = load | wrap;
  assign load_ok   = ({1'b0, load_val} < mod_eff);
  assign load_err  = load & ~load_ok;

  mod_n_mod_ctrl #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_mod_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .mod_wr    (mod_wr),
    .mod_val   (mod_val),
    .apply_req (apply_req),
    .load_err  (load_err),
    .mod_cur   (mod_cur),
    .mod_pend  (mod_pend),
    .mod_err   (mod_err),
    .mod_eff   (mod_eff)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_ok ? load_val : top_val;
    end else if (en && !sat_hold) begin
      if (up_dn == DIR_UP) begin
        cnt_d = at_top ? '0 : cnt_q + WIDTH'(1);
      end else begin
        cnt_d = at_bot ? top_val : cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;
  // Carry/borrow for a cascaded stage, always against the modulus in effect.
  assign tc  = en & ~load & ((up_dn == DIR_UP) ? at_top : at_bot);

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed, table-driven bench for mod_n_updown_counter (WIDTH=4, N=10).
module tb_mod_n_updown_counter;

  localparam int W = 4;

  logic         clk;
  logic         rstn;
  logic         en, up_dn, load, mod_wr;
  logic [W-1:0] load_val;
  logic [W:0]   mod_val;
  logic [W-1:0] out;
  logic         tc;
  logic [W:0]   mod_cur;
  logic         mod_pend;
  logic         mod_err;
`ifdef MODN_SATURATE_EN
  logic         sat;
`endif

  int checks   = 0;
  int failures = 0;

  mod_n_updown_counter #(.WIDTH(W), .N(10)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .mod_wr   (mod_wr),
    .mod_val  (mod_val),
    .out      (out),
    .tc       (tc),
    .mod_cur  (mod_cur),
    .mod_pend (mod_pend),
    .mod_err  (mod_err)
`ifdef MODN_SATURATE_EN
    ,
    .sat      (sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int en, up, ld, ld_val, wr, wval;
    int exp_tc;
    int exp_out, exp_cur, exp_pend, exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    mod_wr = 1'b0; mod_val = '0;
`ifdef MODN_SATURATE_EN
    sat = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rstn = 1'b0;
    #12;
    chk("reset_out", int'(out), 0);
    chk("reset_cur", int'(mod_cur), 10);
    chk("reset_pend", int'(mod_pend), 0);
    chk("reset_err", int'(mod_err), 0);
    chk("reset_tc", int'(tc), 0);
    tick();
    rstn = 1'b1;

    // Up count through two full wraps
    en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 22; k++) begin
      #1;
      chk("up_out", int'(out), k % 10);
      chk("up_tc", int'(tc), (k % 10 == 9) ? 1 : 0);
      tick();
    end
    chk("up_end", int'(out), 2);
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_cur", int'(mod_cur), 10);
    do_reset();

    // Down count from reset
    en = 1'b1; up_dn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      int e;
      e = (10 - (k % 10)) % 10;
      #1;
      chk("dn_out", int'(out), e);
      chk("dn_tc", int'(tc), (e == 0) ? 1 : 0);
      tick();
    end
    do_reset();

    // Runtime modulus change applied at the wrap boundary
    en = 1'b1; up_dn = 1'b1;
    tick(); tick(); tick();
    chk("m6_start", int'(out), 3);
    mod_wr = 1'b1; mod_val = 5'd6;
    tick();
    mod_wr = 1'b0;
    chk("m6_pend", int'(mod_pend), 1);
    chk("m6_cur_old", int'(mod_cur), 10);
    for (int v = 4; v <= 9; v++) begin
      #1;
      chk("m6_pre_out", int'(out), v);
      chk("m6_pre_tc", int'(tc), (v == 9) ? 1 : 0);
      tick();
    end
    chk("m6_cur_new", int'(mod_cur), 6);
    chk("m6_pend_clr", int'(mod_pend), 0);
    for (int v = 0; v <= 5; v++) begin
      #1;
      chk("m6_out", int'(out), v);
      chk("m6_tc", int'(tc), (v == 5) ? 1 : 0);
      tick();
    end
    chk("m6_wrap", int'(out), 0);
    mod_wr = 1'b1; mod_val = 5'd16;
    tick();
    mod_wr = 1'b0;
    chk("m16_pend", int'(mod_pend), 1);
    tick(); tick(); tick(); tick();
    chk("m16_pre", int'(out), 5);
    tick();
    chk("m16_cur", int'(mod_cur), 16);
    for (int v = 0; v <= 15; v++) begin
      #1;
      chk("m16_out", int'(out), v);
      chk("m16_tc", int'(tc), (v == 15) ? 1 : 0);
      tick();
    end
    chk("m16_wrap", int'(out), 0);
    do_reset();

    // Table: illegal modulus, load corner cases, simultaneous write/apply
    //            en up ld lv wr wv  tc  out cur pend err
    vecs.push_back('{0, 1, 0, 0, 1, 1,  0, 0, 10, 0, 1});
    vecs.push_back('{0, 1, 0, 0, 0, 0,  0, 0, 10, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 17, 0, 0, 10, 0, 1});
    vecs.push_back('{0, 1, 0, 0, 0, 0,  0, 0, 10, 0, 0});
    vecs.push_back('{0, 1, 1, 12, 0, 0, 0, 9, 10, 0, 1});
    vecs.push_back('{1, 1, 1, 3, 0, 0,  0, 3, 10, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 0, 0,  0, 4, 10, 0, 0});
    vecs.push_back('{0, 1, 1, 8, 0, 0,  0, 8, 10, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 7,  0, 9, 10, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 5,  1, 0, 7, 1, 0});
    for (int v = 1; v <= 6; v++)
      vecs.push_back('{1, 1, 0, 0, 0, 0, 0, v, 7, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 0, 0,  1, 0, 5, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0,  1, 4, 5, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 8,  0, 4, 5, 1, 0});
    for (int v = 3; v >= 0; v--)
      vecs.push_back('{1, 0, 0, 0, 0, 0, 0, v, 5, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0,  1, 7, 8, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 3,  0, 7, 8, 1, 0});
    vecs.push_back('{0, 1, 1, 5, 0, 0,  0, 2, 3, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 0, 0,  1, 0, 3, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 0, 3, 0, 0});

    foreach (vecs[i]) begin
      en       = vecs[i].en[0];
      up_dn    = vecs[i].up[0];
      load     = vecs[i].ld[0];
      load_val = W'(vecs[i].ld_val);
      mod_wr   = vecs[i].wr[0];
      mod_val  = (W + 1)'(vecs[i].wval);
      #1;
      chk($sformatf("vec%0d_tc", i), int'(tc), vecs[i].exp_tc);
      tick();
      chk($sformatf("vec%0d_out", i), int'(out), vecs[i].exp_out);
      chk($sformatf("vec%0d_cur", i), int'(mod_cur), vecs[i].exp_cur);
      chk($sformatf("vec%0d_pend", i), int'(mod_pend), vecs[i].exp_pend);
      chk($sformatf("vec%0d_err", i), int'(mod_err), vecs[i].exp_err);
    end
    idle_inputs();

`ifdef MODN_SATURATE_EN
    do_reset();
    en = 1'b1; up_dn = 1'b1; sat = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("sat_out", int'(out), (k < 9) ? k : 9);
    end
    #1;
    chk("sat_tc", int'(tc), 1);
    sat = 1'b0;
    tick();
    chk("sat_release", int'(out), 0);
    sat = 1'b1; up_dn = 1'b0;
    #1;
    chk("sat_dn_tc", int'(tc), 1);
    tick();
    chk("sat_dn_out", int'(out), 0);
    idle_inputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
Next-generation modulo-N counter. Counts up or down under enable, supports synchronous preload, and accepts a runtime modulus change. A new modulus is staged and applied only at a wrap boundary or at a load, so no count sequence is ever corrupted. Exposes a terminal-count output for cascading counters and a status view of the current and pending modulus. Used as the general counter/divider primitive in the sequential-circuits library.

Parameters:
- WIDTH, default 4: counter width; out is WIDTH bits.
- N, default 10: modulus after reset. Legal range 2 <= N <= 2**WIDTH; elaboration fails if N is out of range.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  count enable
- up_dn  in  1  direction: 1 = up, 0 = down
- load  in  1  synchronous preload strobe
- load_val  in  WIDTH  preload value
- mod_wr  in  1  modulus write strobe
- mod_val  in  WIDTH+1  requested modulus
- out  out  WIDTH  count value, registered
- tc  out  1  terminal count, combinational
- mod_cur  out  WIDTH+1  modulus currently in effect
- mod_pend  out  1  a staged modulus is waiting
- mod_err  out  1  one-cycle pulse, registered

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low. While rstn=0: out=0, mod_cur=N, mod_pend=0, pending register=0, mod_err=0.
- Per-edge priority: load > count (en) > hold.
- Counting up (en=1, up_dn=1): if out==M-1, out<=0 (wrap); otherwise out<=out+1.
- Counting down (en=1, up_dn=0): if out==0, out<=M-1 (wrap); otherwise out<=out-1.
- Effective modulus M at each edge: the pending value if it is applied at this same edge, otherwise mod_cur.
- en=0 and load=0: out holds; up_dn is don't-care.
- Modulus write:
  - mod_wr=1 with 2 <= mod_val <= 2**WIDTH: value goes to the pending register and mod_pend<=1.
  - A write while a value is already pending overwrites it (last write wins).
  - An illegal mod_val is ignored, and mod_err pulses 1 on the next cycle.
- Applying the pending modulus: at any wrap edge or load edge with mod_pend=1, mod_cur<=pending and mod_pend<=0, on the same edge.
  - Down-wrap uses the new modulus: out<=new M-1.
  - Up-wrap gives out<=0.
- mod_wr on the same edge as an apply: the old pending value is applied, the new value becomes pending, and mod_pend stays 1.
- Load: out<=load_val if load_val < M. Otherwise out<=M-1 and mod_err pulses.
- tc = en & ~load & (up_dn ? out==mod_cur-1 : out==0).
  - It uses mod_cur, not the pending value; it is the carry/borrow for a cascaded stage.
- Latency: out updates 1 cycle after the strobe; tc is zero-latency.
- Reset mid-operation: all state, including the pending modulus, is discarded immediately.
- Width: comparisons use WIDTH+1 bits, so M = 2**WIDTH wraps at all-ones with no overflow.

Optional Feature:
- Macro: MODN_SATURATE_EN.
- When defined:
  - Adds input port sat (1 bit).
  - When sat=1, the counter holds at M-1 (up) or 0 (down) instead of wrapping.
  - While saturated, tc stays high whenever en=1.
  - A pending modulus is applied only by load while sat=1, because no wrap occurs.
- When not defined: no sat port; wrap behaviour is always used.

Decomposition:
- Package mod_n_pkg holds:
  - the direction constants DIR_UP=1 and DIR_DN=0;
  - a function mod_legal(val, width) returning the 2..2**WIDTH range check.
- One sub-module, mod_n_mod_ctrl, holds the mod_cur/pending/mod_pend registers, the legality check, mod_err, and the apply strobe.
- The top level holds the count datapath and tc.

Test Plan:
1. Reset-release then en=1, up_dn=1, 22 cycles, N=10: out = 0..9,0..9,0,1; tc high while out=9. After rstn low mid-count, out=0 immediately (asynchronous).
2. Down count from reset: out = 0,9,8,...,0,9; tc high while out=0.
3. Runtime modulus change:
   - Step 1: mod_wr, mod_val=6 at out=3 (up). Required: mod_pend=1, count continues 4..9. At the 9->0 edge: mod_cur=6, mod_pend=0, then 0..5.
   - Step 2: mod_wr, mod_val=16 with WIDTH=4. Required: full 0..15 wrap.
4. Illegal modulus and load checks:
   - mod_val=1 or 17: ignored, mod_err one-cycle pulse, mod_cur unchanged.
   - load_val=12 with M=10: out=9, mod_err pulses.
   - load=1 and en=1 together: load wins.
5. Simultaneous events: mod_wr of 5 on the edge that applies a pending 7. Required: mod_cur=7, pending=5, mod_pend=1; 5 is applied at the next wrap.
6. MODN_SATURATE_EN build: sat=1, up count at N=10. Required: out stops at 9 and tc stays 1. Then sat=0: the next edge wraps to 0.
